// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit arbiter slice.
//   - FSM state encodings (legacy 2-bit values kept for compatibility)
//   - default emitter timing (cycles per bit, bits per frame)
//   - small helper for sizing counters
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam logic [1:0] GUARD     = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ISSUE     = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  // 27 MHz system clock / 115200 baud
  localparam int unsigned DEFAULT_DELAY_FRAMES = 234;

  // start + 8 data + stop
  localparam int unsigned BITS_PER_FRAME = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. The search starts one past last_grant and
// wraps modulo NUM_REQ; the first set request wins.
// Ports:
//   en          : grant allowed this cycle (no grant when low)
//   req         : request vector
//   last_grant  : index of the most recent winner (pointer held by caller)
//   grant       : one-hot grant
//   grant_idx   : encoded winner index
//   grant_valid : a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] sel;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_grant) + off) % NUM_REQ;
      sel = idx[IDX_W-1:0];
      if (en && !grant_valid && req[sel]) begin
        grant[sel]  = 1'b1;
        grant_idx   = sel;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART emitter among NUM_REQ byte producers, round-robin.
// A won byte is latched and issued as a one-cycle write; the block then waits
// for the emitter ack under a watchdog. After reset or a timeout a guard
// interval lets any frame still in flight in the emitter finish untouched.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester byte valid
//   req_data     : byte of requester i at [8i+7:8i]
//   req_ready    : one-hot acceptance (transfer on valid & ready)
//   tx_data      : byte to emitter
//   tx_write     : one-cycle write strobe to emitter
//   tx_ack       : emitter done level
//   busy         : high whenever not IDLE
//   grant_id     : requester of the current / last sent byte
//   timeout_err  : sticky watchdog flag, cleared by err_clr
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DELAY_FRAMES   = DEFAULT_DELAY_FRAMES,
  parameter int unsigned GUARD_CYCLES   = BITS_PER_FRAME * DELAY_FRAMES + 2,
  parameter int unsigned TIMEOUT_CYCLES = (BITS_PER_FRAME + 2) * DELAY_FRAMES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_write,
  input  logic                       tx_ack,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(max_u(GUARD_CYCLES, TIMEOUT_CYCLES) + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_write_q, tx_write_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .en          (state_q == IDLE),
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Counter saturates rather than wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    tx_write_d    = 1'b0;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    timeout_err_d = timeout_err_q & ~err_clr;

    case (state_q)
      GUARD: begin
        // tx_ack deliberately ignored: emitter may still be finishing a frame.
        if (cnt_q == CW'(GUARD_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (arb_valid) begin
          tx_data_d    = req_data[{arb_idx, 3'b000} +: 8];
          grant_id_d   = arb_idx;
          last_grant_d = arb_idx;
          tx_write_d   = 1'b1;   // registered strobe lands in the ISSUE cycle
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        // cnt==0 masks a stale ack the emitter has not yet cleared.
        if (cnt_q != '0 && tx_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;  // set wins over a simultaneous err_clr
          state_d       = GUARD;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= GUARD;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      tx_write_q    <= 1'b0;
      grant_id_q    <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      tx_write_q    <= tx_write_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = arb_grant;
  assign busy        = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign tx_write    = tx_write_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed + randomized bench with a timestamp-based reference model and a
// behavioural emitter (no reset, 10*DELAY_FRAMES cycles per frame).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int DF      = 4;
  localparam int GUARD_N = 42;
  localparam int TO_N    = 48;
  localparam int FRAME_N = 10 * DF;
  localparam int INF     = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  logic ack_mode  = 1'b0;   // 0: emitter model drives ack, 1: stub value
  logic ack_force = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DELAY_FRAMES   (DF),
    .GUARD_CYCLES   (GUARD_N),
    .TIMEOUT_CYCLES (TO_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_write    (tx_write),
    .tx_ack      (tx_ack),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  // Emitter: no reset, ack low while a frame is being shifted out.
  logic       emu_ack = 1'b1;
  logic       emu_active = 1'b0;
  int         emu_cnt = 0;
  logic [7:0] emu_byte = '0;
  logic [7:0] frames_out[$];

  always @(posedge clk) begin
    if (tx_write) begin
      emu_active <= 1'b1;
      emu_cnt    <= 0;
      emu_ack    <= 1'b0;
      emu_byte   <= tx_data;
    end else if (emu_active) begin
      if (emu_cnt == FRAME_N - 1) begin
        emu_active <= 1'b0;
        emu_ack    <= 1'b1;
        frames_out.push_back(emu_byte);
      end else begin
        emu_cnt <= emu_cnt + 1;
      end
    end
  end

  assign tx_ack = ack_mode ? ack_force : emu_ack;

  // Reference model: t counts clock periods since reset release.
  int         checks = 0;
  int         errors = 0;
  int         t;
  int         m_idle_from;
  bit         m_wait;
  int         m_wr;
  int         m_last;
  logic [7:0] m_txd;
  logic [1:0] m_gid;
  bit         m_err;
  int         n_grants = 0;
  logic [7:0] exp_frames[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++)
      if (((v >> ((last + k) % 4)) & 4'd1) != 4'd0) return (last + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    t           = 0;
    m_idle_from = GUARD_N;
    m_wait      = 1'b0;
    m_wr        = -100;
    m_last      = 3;
    m_txd       = '0;
    m_gid       = '0;
    m_err       = 1'b0;
  endtask

  // Called at posedge+1 with this period's inputs already driven; checks at
  // the negedge, advances the model, returns at the next posedge+1.
  task automatic cycle();
    int          w;
    bit          err_set;
    logic [3:0]  exp_ready;
    logic [31:0] sh;
    @(negedge clk);
    w         = -1;
    exp_ready = '0;
    if (t >= m_idle_from && req_valid != 4'd0) begin
      w         = winner(m_last, req_valid);
      exp_ready = 4'b0001 << w;
    end
    chk("busy", 32'(busy), 32'(t < m_idle_from));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("tx_write", 32'(tx_write), 32'(m_wait && t == m_wr));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));

    err_set = 1'b0;
    if (m_wait && t >= m_wr + 2 && t <= m_wr + TO_N) begin
      if (tx_ack) begin
        m_wait      = 1'b0;
        m_idle_from = t + 1;
      end else if (t == m_wr + TO_N) begin
        m_wait      = 1'b0;
        err_set     = 1'b1;
        m_idle_from = t + 1 + GUARD_N;
      end
    end
    if (w >= 0) begin
      sh          = req_data >> (8 * w);
      m_wait      = 1'b1;
      m_wr        = t + 1;
      m_idle_from = INF;
      m_last      = w;
      m_txd       = sh[7:0];
      m_gid       = 2'(w);
      n_grants++;
      exp_frames.push_back(sh[7:0]);
    end
    if (err_set) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    req_valid = '0;
    n = 0;
    while (t < m_idle_from && n < limit) begin
      cycle();
      n++;
    end
    chk("idle_within_bound", 32'(n < limit), 32'd1);
  endtask

  task automatic grant_one(input logic [3:0] v, input int limit);
    int n;
    int g0;
    g0 = n_grants;
    req_valid = v;
    n = 0;
    while (n_grants == g0 && n < limit) begin
      cycle();
      n++;
    end
    req_valid = '0;
    chk("grant_within_bound", 32'(n < limit), 32'd1);
  endtask

  // Asynchronous reset assertion checked before any clock edge.
  task automatic do_reset();
    req_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("rst_tx_write", 32'(tx_write), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  initial begin
    int n;
    // power-on reset
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    chk("por_busy", 32'(busy), 32'd1);
    chk("por_req_ready", 32'(req_ready), 32'd0);
    chk("por_tx_write", 32'(tx_write), 32'd0);
    chk("por_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    model_reset();

    // 1: single requester through the guard interval
    req_data = 32'h0000_00A5;
    grant_one(4'b0001, 200);
    wait_idle(200);
    chk("t1_busy_after_ack", 32'(busy), 32'd0);

    // 2: all four valid from fresh reset -> 0,1,2,3
    do_reset();
    req_data = 32'h1312_1110;
    n = n_grants;
    req_valid = 4'hF;
    for (int i = 0; i < 600 && n_grants < n + 4; i++) cycle();
    chk("t2_four_grants", 32'(n_grants - n), 32'd4);
    wait_idle(200);

    // 3: requesters 1 and 3 alternate
    req_data = 32'hC3B2_A190;
    n = n_grants;
    req_valid = 4'b1010;
    for (int i = 0; i < 800 && n_grants < n + 6; i++) cycle();
    chk("t3_six_grants", 32'(n_grants - n), 32'd6);
    wait_idle(200);

    // randomized traffic
    for (int i = 0; i < 700; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      cycle();
    end
    wait_idle(200);

    // 4: watchdog with stub holding ack low
    ack_mode  = 1'b1;
    ack_force = 1'b0;
    req_data  = 32'h0000_005A;
    grant_one(4'b0001, 50);
    for (int i = 0; i < 100 && !m_err; i++) cycle();
    chk("t4_timeout_set", 32'(timeout_err), 32'd1);
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("t4_err_cleared", 32'(timeout_err), 32'd0);
    wait_idle(100);
    grant_one(4'b0001, 50);
    n = 0;
    while (!(m_wait && t == m_wr + TO_N) && n < 100) begin
      cycle();
      n++;
    end
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("t4_set_beats_clr", 32'(timeout_err), 32'd1);
    wait_idle(100);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("t4_err_cleared2", 32'(timeout_err), 32'd0);

    // 6: stale ack through ISSUE and first wait cycle, then low for 20
    ack_force = 1'b1;
    req_data  = 32'h00E7_0000;
    grant_one(4'b0100, 50);
    cycle();
    cycle();
    ack_force = 1'b0;
    repeat (20) cycle();
    chk("t6_still_waiting", 32'(busy), 32'd1);
    ack_force = 1'b1;
    wait_idle(10);
    chk("t6_idle_after_rise", 32'(busy), 32'd0);
    repeat (FRAME_N + 5) cycle();
    ack_mode = 1'b0;

    // 5: reset ten cycles into WAIT_DONE, frame survives the guard
    req_data = 32'h0000_0077;
    grant_one(4'b0001, 50);
    n = 0;
    while (t != m_wr + 11 && n < 50) begin
      cycle();
      n++;
    end
    do_reset();
    req_data = 32'h003C_0000;
    grant_one(4'b0100, 100);
    wait_idle(200);
    repeat (5) cycle();

    // every write must reach the emitter intact and in order
    chk("frame_count", 32'(frames_out.size()), 32'(exp_frames.size()));
    for (int i = 0; i < exp_frames.size() && i < frames_out.size(); i++)
      chk("frame_byte", 32'(frames_out[i]), 32'(exp_frames[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
